// File: rtl/hazard_unit_if.sv
// Decode-side inputs and hazard-control outputs of the pipeline hazard unit.
// The pipeline drives through the master modport; the hazard unit is the slave.
interface hazard_unit_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       RA1D;
  logic [3:0]       RA2D;
  logic [3:0]       WA3D;
  logic             RegWriteD;
  logic             MemtoRegD;
  logic             BranchTakenE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, BranchTakenE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    input  StallCount, FlushCount
  );

  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, BranchTakenE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    output StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard unit for a 5-stage pipeline: execute-operand forwarding selects,
// load-use stall, taken-branch flush and saturating stall/flush counters.
// Tracking state: _p0 = execute, _p1 = memory, _p2 = writeback.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  hazard_unit_if.slave hu
);

  logic [3:0]       ra1_p0;
  logic [3:0]       ra2_p0;
  logic [3:0]       wa3_p0;
  logic             regwrite_p0;
  logic             memtoreg_p0;
  logic [3:0]       wa3_p1;
  logic             regwrite_p1;
  logic [3:0]       wa3_p2;
  logic             regwrite_p2;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic             ldr_stall;
  logic             stall;
  logic             flush_d;
  logic             flush_e;

  // Memory stage wins over writeback; R15 (PC) is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic [3:0] wa_m,
    input logic       rw_m,
    input logic [3:0] wa_w,
    input logic       rw_w
  );
    if (ra == 4'd15)             return 2'b00;
    if (rw_m && (wa_m == ra))    return 2'b10;
    if (rw_w && (wa_w == ra))    return 2'b01;
    return 2'b00;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Load-use detection and pipeline control; a taken branch overrides the stall.
  always_comb begin
    ldr_stall = memtoreg_p0 & regwrite_p0 &
                ((wa3_p0 == hu.RA1D) | (wa3_p0 == hu.RA2D));
    stall     = ldr_stall & ~hu.BranchTakenE;
    flush_d   = hu.BranchTakenE;
    flush_e   = ldr_stall | hu.BranchTakenE;
  end

  assign hu.ForwardAE  = fwd_sel(ra1_p0, wa3_p1, regwrite_p1, wa3_p2, regwrite_p2);
  assign hu.ForwardBE  = fwd_sel(ra2_p0, wa3_p1, regwrite_p1, wa3_p2, regwrite_p2);
  assign hu.StallF     = stall;
  assign hu.StallD     = stall;
  assign hu.FlushD     = flush_d;
  assign hu.FlushE     = flush_e;
  assign hu.StallCount = stall_cnt;
  assign hu.FlushCount = flush_cnt;

  // Advance D->E->M->W each cycle, inserting a bubble into E on FlushE, and count events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra1_p0      <= 4'd0;
      ra2_p0      <= 4'd0;
      wa3_p0      <= 4'd0;
      regwrite_p0 <= 1'b0;
      memtoreg_p0 <= 1'b0;
      wa3_p1      <= 4'd0;
      regwrite_p1 <= 1'b0;
      wa3_p2      <= 4'd0;
      regwrite_p2 <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      if (flush_e) begin
        ra1_p0      <= 4'd0;
        ra2_p0      <= 4'd0;
        wa3_p0      <= 4'd0;
        regwrite_p0 <= 1'b0;
        memtoreg_p0 <= 1'b0;
      end else begin
        ra1_p0      <= hu.RA1D;
        ra2_p0      <= hu.RA2D;
        wa3_p0      <= hu.WA3D;
        regwrite_p0 <= hu.RegWriteD;
        memtoreg_p0 <= hu.MemtoRegD;
      end
      wa3_p1      <= wa3_p0;
      regwrite_p1 <= regwrite_p0;
      wa3_p2      <= wa3_p1;
      regwrite_p2 <= regwrite_p1;
      if (stall)   stall_cnt <= sat_inc(stall_cnt);
      if (flush_d) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (16-bit and 2-bit counters) fed the same
// decode stream, compared every cycle against an instruction-level pipeline model,
// with hand-computed expectations for the forwarding, stall, flush and reset cases.
`timescale 1ns/1ps
module tb_hazard_unit;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  logic [3:0] d_ra1, d_ra2, d_wa3;
  logic       d_rw, d_mr, d_bt;

  hazard_unit_if #(.CNT_W(16)) hb ();
  hazard_unit_if #(.CNT_W(2))  hs ();

  assign hb.RA1D = d_ra1;  assign hs.RA1D = d_ra1;
  assign hb.RA2D = d_ra2;  assign hs.RA2D = d_ra2;
  assign hb.WA3D = d_wa3;  assign hs.WA3D = d_wa3;
  assign hb.RegWriteD = d_rw;  assign hs.RegWriteD = d_rw;
  assign hb.MemtoRegD = d_mr;  assign hs.MemtoRegD = d_mr;
  assign hb.BranchTakenE = d_bt;  assign hs.BranchTakenE = d_bt;

  hazard_unit #(.CNT_W(16)) dut_b (.clk(clk), .reset(reset), .hu(hb));
  hazard_unit #(.CNT_W(2))  dut_s (.clk(clk), .reset(reset), .hu(hs));

  // ---------------- instruction-level reference model ----------------
  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic       rw;
    logic       mr;
  } instr_t;

  instr_t pe, pm, pw;          // instructions sitting in E, M, W
  int sc_b, fc_b, sc_s, fc_s;  // expected counter values
  localparam int MAX_B = 65535;
  localparam int MAX_S = 3;

  int n_tests, n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [3:0] ra);
    if (ra == 4'd15) return 2'b00;
    if (pm.rw && pm.wa3 == ra) return 2'b10;
    if (pw.rw && pw.wa3 == ra) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_ldr();
    return pe.mr && pe.rw && (pe.wa3 == d_ra1 || pe.wa3 == d_ra2);
  endfunction

  task automatic model_reset();
    pe = '0; pm = '0; pw = '0;
    sc_b = 0; fc_b = 0; sc_s = 0; fc_s = 0;
  endtask

  task automatic model_adv();
    logic ldr;
    if (reset) return;
    ldr = m_ldr();
    if (ldr && !d_bt) begin
      if (sc_b < MAX_B) sc_b++;
      if (sc_s < MAX_S) sc_s++;
    end
    if (d_bt) begin
      if (fc_b < MAX_B) fc_b++;
      if (fc_s < MAX_S) fc_s++;
    end
    pw = pm;
    pm = pe;
    pe = (ldr || d_bt) ? instr_t'(0) : instr_t'({d_ra1, d_ra2, d_wa3, d_rw, d_mr});
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin : cmp
    logic       ldr;
    logic [1:0] efa, efb;
    ldr = m_ldr();
    efa = m_fwd(pe.ra1);
    efb = m_fwd(pe.ra2);
    chk("cyc_fwdA_b", hb.ForwardAE, efa);
    chk("cyc_fwdB_b", hb.ForwardBE, efb);
    chk("cyc_stallF_b", hb.StallF, ldr & ~d_bt);
    chk("cyc_stallD_b", hb.StallD, ldr & ~d_bt);
    chk("cyc_flushD_b", hb.FlushD, d_bt);
    chk("cyc_flushE_b", hb.FlushE, ldr | d_bt);
    chk("cyc_scnt_b", hb.StallCount, sc_b);
    chk("cyc_fcnt_b", hb.FlushCount, fc_b);
    chk("cyc_fwdA_s", hs.ForwardAE, efa);
    chk("cyc_fwdB_s", hs.ForwardBE, efb);
    chk("cyc_stallD_s", hs.StallD, ldr & ~d_bt);
    chk("cyc_flushE_s", hs.FlushE, ldr | d_bt);
    chk("cyc_scnt_s", hs.StallCount, sc_s);
    chk("cyc_fcnt_s", hs.FlushCount, fc_s);
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_d(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] w,
                       input logic rw, input logic mr, input logic bt);
    d_ra1 = a1; d_ra2 = a2; d_wa3 = w; d_rw = rw; d_mr = mr; d_bt = bt;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    model_adv();
    #1;
  endtask

  function automatic logic [3:0] pick();
    int r;
    r = $urandom_range(0, 5);
    return (r == 5) ? 4'd15 : 4'(r);
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    model_reset();
    set_d(0, 0, 0, 0, 0, 0);

    // reset state
    chk("rst_fwdA", hb.ForwardAE, 0);
    chk("rst_fwdB", hb.ForwardBE, 0);
    chk("rst_stallF", hb.StallF, 0);
    chk("rst_flushE", hb.FlushE, 0);
    chk("rst_scnt", hb.StallCount, 0);
    chk("rst_fcnt", hb.FlushCount, 0);
    tick();
    reset = 1'b0;

    // ALU->ALU forwarding from M
    set_d(0, 0, 3, 1, 0, 0); tick();
    set_d(3, 0, 0, 0, 0, 0); tick();
    set_d(0, 0, 0, 0, 0, 0);
    chk("alu_fwd_m", hb.ForwardAE, 2'b10);
    tick();

    // consumer one instruction later forwards from W
    set_d(0, 0, 3, 1, 0, 0); tick();
    set_d(0, 0, 0, 0, 0, 0); tick();
    set_d(3, 0, 0, 0, 0, 0); tick();
    set_d(0, 0, 0, 0, 0, 0);
    chk("alu_fwd_w", hb.ForwardAE, 2'b01);
    tick();

    // M has priority over W
    set_d(0, 0, 5, 1, 0, 0); tick();
    set_d(0, 0, 5, 1, 0, 0); tick();
    set_d(0, 5, 0, 0, 0, 0); tick();
    set_d(0, 0, 0, 0, 0, 0);
    chk("m_over_w", hb.ForwardBE, 2'b10);
    chk("m_over_w_a", hb.ForwardAE, 2'b00);
    tick();

    // load-use: exactly one stall cycle, then forward from W
    set_d(0, 0, 2, 1, 1, 0); tick();
    set_d(2, 0, 0, 0, 0, 0);
    chk("lu_stallF", hb.StallF, 1);
    chk("lu_stallD", hb.StallD, 1);
    chk("lu_flushE", hb.FlushE, 1);
    chk("lu_flushD", hb.FlushD, 0);
    tick();
    set_d(2, 0, 0, 0, 0, 0);
    chk("lu_stall_gone", hb.StallD, 0);
    chk("lu_flushE_gone", hb.FlushE, 0);
    chk("lu_scnt", hb.StallCount, 1);
    tick();
    set_d(0, 0, 0, 0, 0, 0);
    chk("lu_fwd_w", hb.ForwardAE, 2'b01);
    tick();

    // branch taken during a load-use hazard
    set_d(0, 0, 2, 1, 1, 0); tick();
    set_d(2, 0, 0, 0, 0, 1);
    chk("br_stallF", hb.StallF, 0);
    chk("br_stallD", hb.StallD, 0);
    chk("br_flushD", hb.FlushD, 1);
    chk("br_flushE", hb.FlushE, 1);
    tick();
    set_d(0, 0, 0, 0, 0, 0);
    chk("br_fcnt", hb.FlushCount, 1);
    chk("br_scnt", hb.StallCount, 1);
    tick();

    // R15 never forwarded
    set_d(0, 0, 15, 1, 0, 0); tick();
    set_d(15, 0, 0, 0, 0, 0); tick();
    set_d(0, 0, 0, 0, 0, 0);
    chk("r15_fwd", hb.ForwardAE, 2'b00);
    tick();

    // four more load-use stalls: 2-bit counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      set_d(0, 0, 2, 1, 1, 0); tick();
      set_d(0, 2, 0, 0, 0, 0); tick();
      set_d(0, 2, 0, 0, 0, 0); tick();
    end
    set_d(0, 0, 0, 0, 0, 0);
    chk("sat_scnt_s", hs.StallCount, 3);
    chk("sat_scnt_b", hb.StallCount, 5);
    chk("sat_fcnt_s", hs.FlushCount, 1);
    tick();

    // asynchronous reset mid-cycle clears counters and forwarding at once
    set_d(0, 0, 3, 1, 0, 0); tick();
    set_d(3, 0, 0, 0, 0, 0); tick();
    set_d(0, 0, 0, 0, 0, 0);
    chk("pre_rst_fwd", hs.ForwardAE, 2'b10);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst_scnt_s", hs.StallCount, 0);
    chk("arst_fcnt_s", hs.FlushCount, 0);
    chk("arst_fwdA_s", hs.ForwardAE, 0);
    chk("arst_scnt_b", hb.StallCount, 0);
    tick();
    reset = 1'b0;
    set_d(3, 3, 0, 0, 0, 0);
    chk("post_rst_fwdA", hb.ForwardAE, 0);
    chk("post_rst_fwdB", hb.ForwardBE, 0);
    tick();

    // reset in the middle of a stall discards it
    set_d(0, 0, 4, 1, 1, 0); tick();
    set_d(4, 0, 0, 0, 0, 0);
    chk("mid_stall_on", hb.StallD, 1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("mid_stall_off", hb.StallD, 0);
    chk("mid_flushE_off", hb.FlushE, 0);
    tick();
    reset = 1'b0;
    set_d(4, 4, 0, 0, 0, 0);
    chk("mid_post_stall", hb.StallD, 0);
    chk("mid_post_fwd", hb.ForwardAE, 0);
    tick();

    // randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 600; i++) begin
      set_d(pick(), pick(), pick(), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 99) == 0) begin
        #2;
        reset = 1'b1;
        model_reset();
      end
      tick();
      reset = 1'b0;
    end
    set_d(0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
